ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- Receiver/decoder for the single-wire 800 kHz WS2812 bitstream, clocked at 50 MHz.
- Emulates one WS2812 pixel. It decodes the first 24 bits of a frame into a colour word and latches that word when the reset gap arrives.
- Used as an on-chip loopback checker for the LED driver and as a downstream pixel model in tests.
- Optionally forwards the rest of the frame to the next pixel.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on din (minimum 2).
- T_MIN_HIGH, 5: high pulses shorter than this many cycles are glitches and are ignored.
- T_THRESH, 30: high pulse of T_THRESH cycles or more decodes as 1; shorter decodes as 0 (600 ns).
- T_MAX_HIGH, 60: a high pulse longer than this is a protocol error (1.2 us).
- RESET_CYCLES, 2500: a low time of this many cycles is the reset/latch gap (50 us).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  WS2812 serial data. Asynchronous to clk.
- color  out  24  last latched colour word, raw wire order. The first received bit lands in color[23].
- color_valid  out  1  one-cycle pulse when color is updated.
- frame_err  out  1  one-cycle pulse on a protocol error.
- busy  out  1  high while a frame is in progress (bit_cnt != 0 or state PASS).
- dout  out  1  forwarded data for the downstream pixel (see Optional Feature).

Behaviour:
- Reset and clocking:
  - Reset is rst_n, asynchronous, active-low; clock is clk.
  - Reset values: color=0, color_valid=0, frame_err=0, busy=0, dout=0, state=SYNC, all counters 0.
- Input sampling:
  - din passes through SYNC_STAGES flops to give din_s.
  - Edges are detected on din_s against its registered copy.
  - All timing below is measured on din_s.
- Counters:
  - high_cnt is 7-bit, saturating at 127. It is cleared on a rising edge and increments each cycle din_s=1.
  - low_cnt is 12-bit, saturating at 4095. It is cleared on a falling edge and increments each cycle din_s=0. It equals 1 on the first low cycle.
- State SYNC:
  - Ignore all edges.
  - When low_cnt reaches RESET_CYCLES, go to LOW with bit_cnt=0 and no pulses.
  - Out of reset the line must therefore be idle for one full gap before any decoding.
- State LOW:
  - Rising edge -> HIGH.
  - When low_cnt reaches RESET_CYCLES:
    - bit_cnt=0: no action.
    - bit_cnt 1..23: frame_err pulse, bit_cnt<=0, stay in LOW.
- State HIGH:
  - If high_cnt exceeds T_MAX_HIGH while din_s is still high: frame_err pulse, go to SYNC. The partial word is discarded.
  - On a falling edge with high_cnt < T_MIN_HIGH: glitch. Return to LOW with no bit recorded.
  - On any other falling edge:
    - shift bit (high_cnt >= T_THRESH) into shift_reg from the LSB side;
    - bit_cnt++;
    - if bit_cnt becomes 24: pending<=word, go to PASS;
    - otherwise go to LOW.
- State PASS:
  - Edges are not decoded; dout follows the forwarding rule.
  - When low_cnt reaches RESET_CYCLES: color<=pending, color_valid pulse in that same cycle's registered output, bit_cnt<=0, go to LOW.
  - A high pulse > T_MAX_HIGH in PASS: frame_err pulse, go to SYNC. pending is discarded and color is unchanged.
- Latency:
  - color_valid rises RESET_CYCLES cycles after the final falling edge as seen on din_s.
  - It is never high for 2 consecutive cycles.
- Boundary rules:
  - color only ever changes together with color_valid.
  - A second frame overwrites pending only after the previous latch.
  - A reset gap exactly at a bit boundary (bit_cnt=24) is a valid latch.
  - Asserting rst_n low mid-frame returns to SYNC immediately. Nothing is latched and no pulses are produced.
- Arithmetic: counters saturate; they never wrap.

Optional Feature:
- Macro WS2812_RX_FORWARD_EN.
- Defined:
  - dout=din_s while state==PASS; dout=0 otherwise.
  - The first 24 bits are consumed and the remainder is forwarded with SYNC_STAGES+1 cycles of latency.
  - dout is registered.
- Undefined:
  - dout is tied 0.
  - No forwarding logic is synthesised.

Decomposition:
- Shared package ws2812_pkg holds:
  - timing constants T0H=20, T1H=40, TOTAL=62, RESET=2500 and the new thresholds;
  - the state encoding SYNC/LOW/HIGH/PASS;
  - the colour width 24.
- The driver and this receiver both use the package.
- One sub-module: ws2812_sync_edge, which contains the synchronizer and the rise/fall detector.

Test Plan:
- Reset released with din low for 3000 cycles, then the driver sends 0x12AB34 -> after a 2500-cycle low gap, color=0x12AB34, color_valid pulses once, frame_err stays 0.
- Frame of 48 bits: 0xFF0000 followed by 0x00FF00 -> color=0xFF0000. With WS2812_RX_FORWARD_EN, dout carries exactly the second 24 pulses with identical widths, delayed by 3 cycles.
- 10 bits sent, then 2500 cycles low -> frame_err pulses once, color unchanged, a following valid frame 0x000001 latches correctly.
- A 3-cycle glitch inserted in the low phase mid-frame with word 0xA5A5A5 -> glitch ignored, color=0xA5A5A5.
- din held high for 100 cycles at bit 5 -> frame_err once, state SYNC. Then a full gap and frame 0x0F0F0F -> latched.
- rst_n asserted at bit 12 -> all outputs 0 the same cycle. After release, a gap and frame 0x800000 -> color=0x800000.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: nominal driver timing, receiver decode
// thresholds (all in 50 MHz clock cycles), colour width and receiver states.
package ws2812_pkg;

   // Nominal driver timing.
   localparam int T0H   = 20;
   localparam int T1H   = 40;
   localparam int TOTAL = 62;
   localparam int RESET = 2500;

   // Receiver decode thresholds.
   localparam int MIN_HIGH_CYC = 5;
   localparam int THRESH_CYC   = 30;
   localparam int MAX_HIGH_CYC = 60;
   localparam int RESET_CYC    = 2500;

   localparam int COLOR_W    = 24;
   localparam int HIGH_CNT_W = 7;
   localparam int LOW_CNT_W  = 12;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_LOW,
      ST_HIGH,
      ST_PASS
   } state_e;

endpackage

// File: rtl/ws2812_sync_edge.sv
// Synchronises the asynchronous WS2812 data line and flags its rising and
// falling edges, one cycle wide, on the synchronised copy.
module ws2812_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_din,
   output logic o_din_s,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_din_d;

   // Synchroniser chain plus a delayed copy for edge detection.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_din_d <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_din};
         r_din_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_din_s = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_din_d;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_din_d;

endmodule

// File: rtl/ws2812_rx.sv
// Single-pixel WS2812 receiver: decodes the first 24 bits of a frame and
// latches them as the colour word when the reset gap arrives.
// Define WS2812_RX_FORWARD_EN to forward the rest of the frame on dout.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int T_MIN_HIGH   = MIN_HIGH_CYC,
   parameter int T_THRESH     = THRESH_CYC,
   parameter int T_MAX_HIGH   = MAX_HIGH_CYC,
   parameter int RESET_CYCLES = RESET_CYC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               din,
   output logic [COLOR_W-1:0] color,
   output logic               color_valid,
   output logic               frame_err,
   output logic               busy,
   output logic               dout
);

   localparam logic [HIGH_CNT_W-1:0] L_MIN_HIGH = HIGH_CNT_W'(T_MIN_HIGH);
   localparam logic [HIGH_CNT_W-1:0] L_THRESH   = HIGH_CNT_W'(T_THRESH);
   localparam logic [HIGH_CNT_W-1:0] L_MAX_HIGH = HIGH_CNT_W'(T_MAX_HIGH);
   localparam logic [LOW_CNT_W-1:0]  L_GAP      = LOW_CNT_W'(RESET_CYCLES);

   logic w_din_s, w_rise, w_fall;

   state_e                r_state, w_state_nxt;
   logic [HIGH_CNT_W-1:0] r_high_cnt, w_high_inc;
   logic [LOW_CNT_W-1:0]  r_low_cnt, w_low_inc;
   logic [4:0]            r_bit_cnt, w_bit_cnt_nxt;
   // Doubles as the pending word once bit_cnt reaches 24; frozen in PASS.
   logic [COLOR_W-1:0]    r_shift, w_shift_nxt;
   logic [COLOR_W-1:0]    r_color, w_color_nxt;
   logic                  r_valid, w_valid_nxt;
   logic                  r_err, w_err_nxt;
   logic                  r_busy;
   logic                  w_gap, w_too_long, w_bit;

   ws2812_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_din   (din),
      .o_din_s (w_din_s),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // Run lengths including the current cycle; restart at 1 on an edge, saturate.
   assign w_high_inc = w_rise ? HIGH_CNT_W'(1) :
                       (&r_high_cnt ? r_high_cnt : r_high_cnt + 1'b1);
   assign w_low_inc  = w_fall ? LOW_CNT_W'(1) :
                       (&r_low_cnt ? r_low_cnt : r_low_cnt + 1'b1);
   assign w_gap      = ~w_din_s & (w_low_inc == L_GAP);
   assign w_too_long = w_din_s & (w_high_inc > L_MAX_HIGH);
   assign w_bit      = (r_high_cnt >= L_THRESH);

   // Next-state and pulse decode.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_color_nxt   = r_color;
      w_valid_nxt   = 1'b0;
      w_err_nxt     = 1'b0;
      case (r_state)
         ST_SYNC: begin
            if (w_gap) begin
               w_state_nxt   = ST_LOW;
               w_bit_cnt_nxt = '0;
            end
         end
         ST_LOW: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
            end else if (w_gap && r_bit_cnt != '0) begin
               w_err_nxt     = 1'b1;
               w_bit_cnt_nxt = '0;
            end
         end
         ST_HIGH: begin
            if (w_too_long) begin
               w_err_nxt     = 1'b1;
               w_bit_cnt_nxt = '0;
               w_state_nxt   = ST_SYNC;
            end else if (w_fall) begin
               if (r_high_cnt < L_MIN_HIGH) begin
                  w_state_nxt = ST_LOW;
               end else begin
                  w_shift_nxt   = {r_shift[COLOR_W-2:0], w_bit};
                  w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                  w_state_nxt   = (r_bit_cnt == 5'd23) ? ST_PASS : ST_LOW;
               end
            end
         end
         ST_PASS: begin
            if (w_too_long) begin
               w_err_nxt     = 1'b1;
               w_bit_cnt_nxt = '0;
               w_state_nxt   = ST_SYNC;
            end else if (w_gap) begin
               w_color_nxt   = r_shift;
               w_valid_nxt   = 1'b1;
               w_bit_cnt_nxt = '0;
               w_state_nxt   = ST_LOW;
            end
         end
         default: w_state_nxt = ST_SYNC;
      endcase
   end

   // Line run-length counters; each holds while the line is in the other level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_high_cnt <= '0;
         r_low_cnt  <= '0;
      end else if (w_din_s) begin
         r_high_cnt <= w_high_inc;
      end else begin
         r_low_cnt  <= w_low_inc;
      end
   end

   // Decoder state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_SYNC;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_color   <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_color   <= w_color_nxt;
         r_valid   <= w_valid_nxt;
         r_err     <= w_err_nxt;
         r_busy    <= (w_bit_cnt_nxt != '0) || (w_state_nxt == ST_PASS);
      end
   end

   assign color       = r_color;
   assign color_valid = r_valid;
   assign frame_err   = r_err;
   assign busy        = r_busy;

`ifdef WS2812_RX_FORWARD_EN
   logic r_dout;

   // Pass the synchronised line through once this pixel has its 24 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout <= 1'b0;
      end else begin
         r_dout <= (r_state == ST_PASS) ? w_din_s : 1'b0;
      end
   end

   assign dout = r_dout;
`else
   assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomised bench for ws2812_rx: a driver emits WS2812 pulses with random
// legal widths; expected latches, errors and forwarded pulses are queued
// and compared by a monitor whenever the DUT produces them.
module tb_ws2812_rx;
   import ws2812_pkg::*;

   localparam int SYNC_STAGES  = 2;
   localparam int T_MIN_HIGH   = MIN_HIGH_CYC;
   localparam int T_THRESH     = THRESH_CYC;
   localparam int T_MAX_HIGH   = MAX_HIGH_CYC;
   localparam int RESET_CYCLES = RESET_CYC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        din = 1'b0;
   logic [23:0] color;
   logic        color_valid, frame_err, busy, dout;

   always #10 clk = ~clk;

   ws2812_rx #(
      .SYNC_STAGES  (SYNC_STAGES),
      .T_MIN_HIGH   (T_MIN_HIGH),
      .T_THRESH     (T_THRESH),
      .T_MAX_HIGH   (T_MAX_HIGH),
      .RESET_CYCLES (RESET_CYCLES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .color       (color),
      .color_valid (color_valid),
      .frame_err   (frame_err),
      .busy        (busy),
      .dout        (dout)
   );

   typedef struct {int cyc; logic [23:0] color;} lat_t;
   typedef struct {int cyc; int width;} fwd_t;

   lat_t sb_q[$];
   fwd_t fwd_q[$];

   int n_checks = 0;
   int n_errs = 0;
   int cyc = 0;
   int last_fall_cyc = 0;
   int exp_frame_errs = 0;
   int act_frame_errs = 0;
   int dout_high_cycles = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every latch against the scoreboard, count error pulses.
   logic [23:0] prev_color = '0;
   logic        prev_valid = 1'b0;
   logic        prev_dout = 1'b0;
   int          dout_rise_cyc = 0;
   always @(negedge clk) begin : monitor
      lat_t e;
      fwd_t f;
      if (rst_n) begin
         if (color_valid) begin
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errs++;
               $display("FAIL unexpected_latch actual=%0h expected=none (cycle %0d)", color, cyc);
            end else begin
               e = sb_q.pop_front();
               check("latched_color", 32'(color), 32'(e.color));
               check("latch_cycle", cyc, e.cyc);
            end
         end else if (color !== prev_color) begin
            check("color_hold", 32'(color), 32'(prev_color));
         end
         if (frame_err) act_frame_errs <= act_frame_errs + 1;
`ifdef WS2812_RX_FORWARD_EN
         if (dout && !prev_dout) dout_rise_cyc <= cyc;
         if (!dout && prev_dout) begin
            if (fwd_q.size() == 0) begin
               n_checks++;
               n_errs++;
               $display("FAIL unexpected_fwd_pulse actual=%0d expected=none (cycle %0d)", cyc - dout_rise_cyc, cyc);
            end else begin
               f = fwd_q.pop_front();
               check("fwd_rise_cycle", dout_rise_cyc, f.cyc);
               check("fwd_width", cyc - dout_rise_cyc, f.width);
            end
         end
`else
         if (dout) dout_high_cycles <= dout_high_cycles + 1;
`endif
      end
      prev_color <= color;
      prev_valid <= color_valid;
      prev_dout  <= dout;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Random legal high time for a bit; occasionally the nominal driver width.
   function automatic int pick_hi(input logic b);
      if ($urandom_range(0, 3) == 0) return b ? T1H : T0H;
      return b ? int'($urandom_range(T_MAX_HIGH, T_THRESH))
               : int'($urandom_range(T_THRESH - 1, T_MIN_HIGH));
   endfunction

   task automatic pulse(input int hi, input int lo, input bit fwd);
      din = 1'b1;
`ifdef WS2812_RX_FORWARD_EN
      if (fwd) fwd_q.push_back('{cyc + SYNC_STAGES + 1, hi});
`endif
      tick(hi);
      din = 1'b0;
      last_fall_cyc = cyc;
      tick(lo);
   endtask

   // Send the first n bits of w (MSB first); bits past 24 are forwarded.
   task automatic send_bits(input logic [47:0] w, input int n, input int glitch_at);
      logic [47:0] v;
      int hi;
      v = w;
      for (int i = 0; i < n; i++) begin
         hi = pick_hi(v[47 - i]);
         pulse(hi, TOTAL - hi + int'($urandom_range(0, 8)), i >= 24);
         if (i == glitch_at) begin
            din = 1'b1;
            tick(3);
            din = 1'b0;
            tick(12);
         end
      end
   endtask

   // A full frame followed by a reset gap; the latch is expected
   // RESET_CYCLES cycles after the last fall reaches din_s.
   task automatic send_frame(input logic [23:0] w, input int glitch_at);
      send_bits({w, 24'h0}, 24, glitch_at);
      sb_q.push_back('{last_fall_cyc + SYNC_STAGES + RESET_CYCLES, w});
      tick(RESET_CYCLES + 100);
   endtask

   task automatic checkpoint(input string name);
      check({name, "_frame_errs"}, act_frame_errs, exp_frame_errs);
      check({name, "_sb_drained"}, sb_q.size(), 0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_color"}, 32'(color), 32'd0);
      check({name, "_valid"}, 32'(color_valid), 32'd0);
      check({name, "_err"}, 32'(frame_err), 32'd0);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_dout"}, 32'(dout), 32'd0);
   endtask

   initial begin : watchdog
      #(90000 * 20);
      $display("FAIL watchdog actual=timeout expected=finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [23:0] rw;
      // Reset, then one full idle gap to leave SYNC.
      tick(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      tick(5);
      check_all_zero("post_reset");
      tick(3000);

      send_frame(24'h12AB34, -1);
      checkpoint("basic");

      // 48-bit frame: first word latched, second word forwarded.
      send_bits({24'hFF0000, 24'h00FF00}, 48, -1);
      sb_q.push_back('{last_fall_cyc + SYNC_STAGES + RESET_CYCLES, 24'hFF0000});
      tick(RESET_CYCLES + 100);
      checkpoint("two_words");

      // Truncated frame: error on the gap, colour kept.
      send_bits({24'h5A5A5A, 24'h0}, 10, -1);
      check("short_busy", 32'(busy), 32'd1);
      tick(RESET_CYCLES + 100);
      exp_frame_errs++;
      checkpoint("short_frame");
      check("short_color_kept", 32'(color), 32'hFF0000);
      check("short_busy_clear", 32'(busy), 32'd0);
      send_frame(24'h000001, -1);

      // Short glitch in a low phase mid-frame.
      send_frame(24'hA5A5A5, 11);
      checkpoint("glitch");

      // Stuck-high line at bit 5, then a frame without a gap is ignored.
      send_bits({24'hC3C3C3, 24'h0}, 5, -1);
      din = 1'b1;
      tick(100);
      din = 1'b0;
      exp_frame_errs++;
      tick(200);
      check("stuck_busy_clear", 32'(busy), 32'd0);
      send_bits({24'h333333, 24'h0}, 24, -1);
      check("sync_ignores_busy", 32'(busy), 32'd0);
      tick(RESET_CYCLES + 100);
      send_frame(24'h0F0F0F, -1);
      checkpoint("stuck_high");

      // Asynchronous reset mid-frame clears everything at once.
      send_bits({24'h777777, 24'h0}, 12, -1);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      tick(3);
      rst_n = 1'b1;
      tick(RESET_CYCLES + 100);
      send_frame(24'h800000, -1);
      checkpoint("after_reset");

      // Random words.
      for (int k = 0; k < 2; k++) begin
         rw = 24'($urandom);
         send_frame(rw, -1);
      end

      tick(100);
      checkpoint("final");
`ifdef WS2812_RX_FORWARD_EN
      check("fwd_drained", fwd_q.size(), 0);
`else
      check("dout_idle", dout_high_cycles, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
